// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared widths, register-file geometry and requester indices
package rf_wb_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN_DEF   = 32;
    localparam int REQ_PIPE   = 0;
    localparam int REQ_LSU    = 1;
    localparam int REQ_MDU    = 2;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bit per architectural register for outstanding long-latency writes
//   clk, reset       : clock, asynchronous active-high reset
//   set_en, set_rd   : mark set_rd busy (set beats a same-cycle clear)
//   clr_en, clr_rd   : release clr_rd when its long-latency write transfers
//   q_issue/q_rs1/q_rs2 -> issue_busy/rs1_busy/rs2_busy : busy queries (x0 never busy)
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      set_en,
    input  reg_addr_t set_rd,
    input  logic      clr_en,
    input  reg_addr_t clr_rd,
    input  reg_addr_t q_issue,
    input  reg_addr_t q_rs1,
    input  reg_addr_t q_rs2,
    output logic      issue_busy,
    output logic      rs1_busy,
    output logic      rs2_busy
);
    logic [NUM_REGS-1:0] busy, busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_rd] = 1'b0;
        if (set_en) busy_nxt[set_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) busy <= '0;
        else       busy <= busy_nxt;

    assign issue_busy = busy[q_issue];
    assign rs1_busy   = busy[q_rs1];
    assign rs2_busy   = busy[q_rs2];
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between pipeline and long-latency writeback
//   clk, reset                  : clock, asynchronous active-high reset
//   issue_valid/issue_rd/issue_ready : decode issue of a long-latency op, blocked on busy rd (WAW)
//   req_valid/req_rd/req_wd/req_ready : per-requester writeback handshake, index 0 = pipeline
//   pipe_stall                  : masks the pipeline requester after repeated refusals of others
//   rf_we/rf_rd/rf_wd           : registered register-file write
//   rs1/rs2 -> rsX_busy/rsX_fwd, fwd_wd : decode hazard and forwarding status
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int XLEN         = XLEN_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [REG_ADDR_W-1:0]   issue_rd,
    output logic                    issue_ready,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [REG_ADDR_W*N_REQ-1:0] req_rd,
    input  logic [XLEN*N_REQ-1:0]   req_wd,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    pipe_stall,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_rd,
    output logic [XLEN-1:0]         rf_wd,
    input  logic [REG_ADDR_W-1:0]   rs1,
    input  logic [REG_ADDR_W-1:0]   rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    rs1_fwd,
    output logic                    rs2_fwd,
    output logic [XLEN-1:0]         fwd_wd
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0]         ptr, ptr_nxt;
    logic [CW-1:0]         cnt, cnt_inc;
    logic [N_REQ-1:0]      grant;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_wd;
    logic                  found, xfer, long_xfer, waiting, issue_busy;
    int                    k;

    // Pipeline wins unless stalled; otherwise round-robin over 1..N_REQ-1 from ptr.
    always_comb begin
        grant   = '0;
        sel_rd  = req_rd[REQ_PIPE*REG_ADDR_W +: REG_ADDR_W];
        sel_wd  = req_wd[REQ_PIPE*XLEN +: XLEN];
        ptr_nxt = ptr;
        found   = 1'b0;
        k       = 0;
        if (!pipe_stall && req_valid[REQ_PIPE]) begin
            grant[REQ_PIPE] = 1'b1;
        end else begin
            for (int j = 0; j < N_REQ - 1; j++) begin
                k = (int'(ptr) - 1 + j) % (N_REQ - 1) + 1;
                if (!found && req_valid[k]) begin
                    found    = 1'b1;
                    grant[k] = 1'b1;
                    sel_rd   = req_rd[k*REG_ADDR_W +: REG_ADDR_W];
                    sel_wd   = req_wd[k*XLEN +: XLEN];
                    ptr_nxt  = (k == N_REQ - 1) ? PW'(REQ_LSU) : PW'(k + 1);
                end
            end
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;
    assign long_xfer = |grant[N_REQ-1:1];
    assign waiting   = |req_valid[N_REQ-1:1];
    assign cnt_inc   = (cnt == CW'(STARVE_LIMIT)) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wd      <= '0;
            ptr        <= PW'(REQ_LSU);
            cnt        <= '0;
            pipe_stall <= 1'b0;
        end else begin
            rf_we <= xfer;
            if (xfer) begin
                rf_rd <= sel_rd;
                rf_wd <= sel_wd;
            end
            if (long_xfer) begin
                ptr        <= ptr_nxt;
                cnt        <= '0;
                pipe_stall <= 1'b0;
            end else if (waiting && grant[REQ_PIPE]) begin
                cnt        <= cnt_inc;
                pipe_stall <= cnt_inc >= CW'(STARVE_LIMIT);
            end
        end

    rf_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .set_en     (issue_valid && issue_ready && issue_rd != '0),
        .set_rd     (issue_rd),
        .clr_en     (long_xfer),
        .clr_rd     (sel_rd),
        .q_issue    (issue_rd),
        .q_rs1      (rs1),
        .q_rs2      (rs2),
        .issue_busy (issue_busy),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy)
    );

    assign issue_ready = (issue_rd == '0) || !issue_busy;
    assign rs1_fwd     = rf_we && rf_rd == rs1 && rs1 != '0;
    assign rs2_fwd     = rf_we && rf_rd == rs2 && rs2 != '0;
    assign fwd_wd      = rf_wd;
endmodule
